// File: rtl/samp_capture_ctrl.sv
// Capture sequencer for the 32-entry sample bank: arm, trigger, decimated write, then ordered readout.
// Optional ARMED timeout is compiled in with `define ARM_TIMEOUT_EN.
module samp_capture_ctrl #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 8,
   parameter int TO_W  = 16
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          ARM,
   input  logic          ABORT,
   input  logic          TRIG,
   input  logic [AW:0]   CAP_LEN,
   input  logic [3:0]    DECIM,
   input  logic [DW-1:0] RAW_DATA,
   input  logic          RAW_VALID,
   output logic [DW-1:0] SAMP_DATA,
   output logic          SAMP_VALID,
   output logic [AW-1:0] RD_IDX,
   input  logic [DW-1:0] RD_DATA,
   output logic [DW-1:0] STRM_DATA,
   output logic          STRM_VALID,
   input  logic          STRM_READY,
   output logic          STRM_LAST,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR
);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_FLUSH, S_READOUT} state_t;

   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_P   = AW'(1);

   state_t        state_q, state_d;
   logic [AW:0]   len_q, len_d, cap_cnt_q, cap_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [AW-1:0] base_q, base_d, wr_ptr_q, wr_ptr_d;
   logic [3:0]    decim_q, decim_d, dec_cnt_q, dec_cnt_d;
   logic [DW-1:0] samp_data_q, samp_data_d;
   logic          samp_valid_q, samp_valid_d, err_q, err_d, done_q, done_d;
   logic          len_ok, rd_last;

`ifdef ARM_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
   logic [TO_W-1:0] unused_to;
   assign unused_to = '0;
`endif

   assign len_ok  = (CAP_LEN != '0) && (CAP_LEN <= DEPTH_L);
   assign rd_last = (rd_cnt_q == len_q - ONE_L);

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      decim_d      = decim_q;
      base_d       = base_q;
      wr_ptr_d     = wr_ptr_q;
      cap_cnt_d    = cap_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      dec_cnt_d    = dec_cnt_q;
      samp_data_d  = samp_data_q;
      samp_valid_d = 1'b0;
      err_d        = err_q;
      done_d       = 1'b0;
`ifdef ARM_TIMEOUT_EN
      to_cnt_d     = to_cnt_q;
`endif
      if (ABORT) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (ARM) begin
               if (len_ok) begin
                  len_d     = CAP_LEN;
                  decim_d   = DECIM;
                  base_d    = wr_ptr_q;
                  cap_cnt_d = '0;
                  dec_cnt_d = '0;
                  err_d     = 1'b0;
`ifdef ARM_TIMEOUT_EN
                  to_cnt_d  = '0;
`endif
                  state_d   = S_ARMED;
               end else begin
                  err_d = 1'b1;
               end
            end
            S_ARMED: begin
               if (TRIG) state_d = S_CAPTURE;
`ifdef ARM_TIMEOUT_EN
               else if (to_cnt_q == '1) begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end else to_cnt_d = to_cnt_q + TO_ONE;
`endif
            end
            S_CAPTURE: if (RAW_VALID) begin
               if (dec_cnt_q == decim_q) begin
                  dec_cnt_d    = '0;
                  samp_valid_d = 1'b1;
                  samp_data_d  = RAW_DATA;
                  cap_cnt_d    = cap_cnt_q + ONE_L;
                  wr_ptr_d     = wr_ptr_q + ONE_P;
                  if (cap_cnt_q + ONE_L == len_q) state_d = S_FLUSH;
               end else begin
                  dec_cnt_d = dec_cnt_q + 4'd1;
               end
            end
            // One idle cycle lets the bank commit the final write before it is read back.
            S_FLUSH: begin
               rd_cnt_d = '0;
               state_d  = S_READOUT;
            end
            S_READOUT: if (STRM_READY) begin
               if (rd_last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  rd_cnt_d = rd_cnt_q + ONE_L;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         decim_q      <= '0;
         base_q       <= '0;
         wr_ptr_q     <= '0;
         cap_cnt_q    <= '0;
         rd_cnt_q     <= '0;
         dec_cnt_q    <= '0;
         samp_data_q  <= '0;
         samp_valid_q <= 1'b0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         decim_q      <= decim_d;
         base_q       <= base_d;
         wr_ptr_q     <= wr_ptr_d;
         cap_cnt_q    <= cap_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         dec_cnt_q    <= dec_cnt_d;
         samp_data_q  <= samp_data_d;
         samp_valid_q <= samp_valid_d;
         err_q        <= err_d;
         done_q       <= done_d;
      end
   end

`ifdef ARM_TIMEOUT_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) to_cnt_q <= '0;
      else        to_cnt_q <= to_cnt_d;
   end
`endif

   assign SAMP_DATA  = samp_data_q;
   assign SAMP_VALID = samp_valid_q;
   assign STRM_VALID = (state_q == S_READOUT);
   assign RD_IDX     = STRM_VALID ? base_q + rd_cnt_q[AW-1:0] : '0;
   assign STRM_DATA  = STRM_VALID ? RD_DATA : '0;
   assign STRM_LAST  = STRM_VALID && rd_last;
   assign BUSY       = (state_q != S_IDLE);
   assign DONE       = done_q;
   assign ERR        = err_q;

endmodule

// File: tb/tb_samp_capture_ctrl.sv
// Directed bench for samp_capture_ctrl with a behavioural 32-entry bank on the write/read ports.
module tb_samp_capture_ctrl;

`ifdef ARM_TIMEOUT_EN
   localparam int TB_TO_W = 4;
`else
   localparam int TB_TO_W = 16;
`endif

   logic       CLK = 1'b0, RST_N = 1'b0;
   logic       ARM = 1'b0, ABORT = 1'b0, TRIG = 1'b0, RAW_VALID = 1'b0, STRM_READY = 1'b0;
   logic [5:0] CAP_LEN = '0;
   logic [3:0] DECIM = '0;
   logic [7:0] RAW_DATA = '0, RD_DATA, SAMP_DATA, STRM_DATA;
   logic [4:0] RD_IDX;
   logic       SAMP_VALID, STRM_VALID, STRM_LAST, BUSY, DONE, ERR;

   int checks = 0, errors = 0;
   logic [7:0] exp_d [0:31];

   samp_capture_ctrl #(.DEPTH(32), .AW(5), .DW(8), .TO_W(TB_TO_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .ARM(ARM), .ABORT(ABORT), .TRIG(TRIG),
      .CAP_LEN(CAP_LEN), .DECIM(DECIM), .RAW_DATA(RAW_DATA), .RAW_VALID(RAW_VALID),
      .SAMP_DATA(SAMP_DATA), .SAMP_VALID(SAMP_VALID), .RD_IDX(RD_IDX), .RD_DATA(RD_DATA),
      .STRM_DATA(STRM_DATA), .STRM_VALID(STRM_VALID), .STRM_READY(STRM_READY),
      .STRM_LAST(STRM_LAST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // Sample bank: wrapping write counter, combinational read.
   logic [7:0] bank [0:31];
   logic [4:0] bwp;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bwp <= '0;
         for (int i = 0; i < 32; i++) bank[i] <= '0;
      end else if (SAMP_VALID) begin
         bank[bwp] <= SAMP_DATA;
         bwp       <= bwp + 5'd1;
      end
   end
   assign RD_DATA = bank[RD_IDX];

   task automatic do_arm(input logic [5:0] len, input logic [3:0] dec);
      @(negedge CLK); ARM = 1'b1; CAP_LEN = len; DECIM = dec;
      @(negedge CLK); ARM = 1'b0;
   endtask

   task automatic do_trig;
      TRIG = 1'b1;
      @(negedge CLK); TRIG = 1'b0;
   endtask

   task automatic feed(input int n, input logic [7:0] d0, input logic [7:0] step, input int dec, input string nm);
      logic       kept;
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = 8'(d0 + step * i);
         RAW_VALID = 1'b1; RAW_DATA = d;
         @(negedge CLK);
         kept = ((i % (dec + 1)) == dec);
         checks++;
         if (SAMP_VALID !== kept || (kept && SAMP_DATA !== d)) begin
            errors++;
            $display("FAIL %s samp[%0d]: got v=%b d=%h want v=%b d=%h", nm, i, SAMP_VALID, SAMP_DATA, kept, d);
         end
      end
      RAW_VALID = 1'b0;
   endtask

   // Called at the negedge of the FLUSH cycle; pat[k%4] is READY in readout cycle k.
   task automatic readout(input int n, input logic [4:0] base, input logic [3:0] pat, input string nm);
      int b = 0, cyc = 0;
      logic rdy;
      checks++;
      if (BUSY !== 1'b1 || STRM_VALID !== 1'b0) begin
         errors++;
         $display("FAIL %s flush: got busy=%b valid=%b want 1 0", nm, BUSY, STRM_VALID);
      end
      STRM_READY = 1'b0;
      while (b < n && cyc < 200) begin
         @(negedge CLK);
         checks++;
         if (STRM_VALID !== 1'b1 || STRM_DATA !== exp_d[b] || RD_IDX !== 5'(base + b) || STRM_LAST !== (b == n - 1)) begin
            errors++;
            $display("FAIL %s beat%0d: got v=%b d=%h idx=%0d last=%b want 1 %h %0d %b",
                     nm, b, STRM_VALID, STRM_DATA, RD_IDX, STRM_LAST, exp_d[b], 5'(base + b), (b == n - 1));
         end
         rdy = pat[cyc % 4];
         STRM_READY = rdy;
         if (rdy) b++;
         cyc++;
      end
      checks++;
      if (b != n) begin
         errors++;
         $display("FAIL %s timeout: got beats=%0d want %0d", nm, b, n);
      end
      @(negedge CLK); STRM_READY = 1'b0;
      checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0 || STRM_VALID !== 1'b0) begin
         errors++;
         $display("FAIL %s done: got done=%b busy=%b valid=%b want 1 0 0", nm, DONE, BUSY, STRM_VALID);
      end
      @(negedge CLK);
      checks++;
      if (DONE !== 1'b0) begin
         errors++;
         $display("FAIL %s done_pulse: got %b want 0", nm, DONE);
      end
   endtask

   task automatic test_reset;
      @(negedge CLK);
      checks++;
      if ({SAMP_DATA, SAMP_VALID, RD_IDX, STRM_DATA, STRM_VALID, STRM_LAST, BUSY, DONE, ERR} !== '0) begin
         errors++;
         $display("FAIL reset: got %h want 0", {SAMP_DATA, SAMP_VALID, RD_IDX, STRM_DATA, STRM_VALID, STRM_LAST, BUSY, DONE, ERR});
      end
      RST_N = 1'b1;
   endtask

   task automatic test_basic;
      do_arm(6'd4, 4'd0);
      checks++;
      if (BUSY !== 1'b1 || ERR !== 1'b0) begin
         errors++;
         $display("FAIL basic_arm: got busy=%b err=%b want 1 0", BUSY, ERR);
      end
      do_trig();
      feed(4, 8'h11, 8'h11, 0, "basic");
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
      readout(4, 5'd0, 4'b1111, "basic");
   endtask

   task automatic test_full_wrap;
      do_arm(6'd32, 4'd0);
      do_trig();
      feed(32, 8'h80, 8'h01, 0, "wrap");
      for (int i = 0; i < 32; i++) exp_d[i] = 8'(8'h80 + i);
      readout(32, 5'd4, 4'b1111, "wrap");
   endtask

   task automatic test_decim;
      do_arm(6'd3, 4'd2);
      do_trig();
      feed(9, 8'h00, 8'h01, 2, "decim");
      exp_d[0] = 8'h02; exp_d[1] = 8'h05; exp_d[2] = 8'h08;
      readout(3, 5'd4, 4'b1111, "decim");
   endtask

   task automatic test_stall;
      do_arm(6'd4, 4'd0);
      do_trig();
      feed(4, 8'h50, 8'h01, 0, "stall");
      exp_d[0] = 8'h50; exp_d[1] = 8'h51; exp_d[2] = 8'h52; exp_d[3] = 8'h53;
      readout(4, 5'd7, 4'b1001, "stall");
   endtask

   task automatic test_err;
      do_arm(6'd0, 4'd0);
      checks++;
      if (ERR !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL err_len0: got err=%b busy=%b want 1 0", ERR, BUSY);
      end
      do_arm(6'd33, 4'd0);
      checks++;
      if (ERR !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL err_len33: got err=%b busy=%b want 1 0", ERR, BUSY);
      end
   endtask

   task automatic test_abort;
      do_arm(6'd8, 4'd0);
      checks++;
      if (ERR !== 1'b0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL abort_arm: got err=%b busy=%b want 0 1", ERR, BUSY);
      end
      do_arm(6'd0, 4'd0);
      checks++;
      if (ERR !== 1'b0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL arm_busy: got err=%b busy=%b want 0 1", ERR, BUSY);
      end
      do_trig();
      feed(2, 8'h60, 8'h01, 0, "abort");
      ABORT = 1'b1;
      @(negedge CLK); ABORT = 1'b0;
      checks++;
      if (BUSY !== 1'b0 || SAMP_VALID !== 1'b0 || DONE !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got busy=%b sv=%b done=%b want 0 0 0", BUSY, SAMP_VALID, DONE);
      end
      @(negedge CLK);
      checks++;
      if (DONE !== 1'b0) begin
         errors++;
         $display("FAIL abort_done: got %b want 0", DONE);
      end
      do_arm(6'd2, 4'd0);
      do_trig();
      feed(2, 8'hA0, 8'h01, 0, "post_abort");
      exp_d[0] = 8'hA0; exp_d[1] = 8'hA1;
      readout(2, 5'd13, 4'b1111, "post_abort");
   endtask

   task automatic test_reset_mid;
      do_arm(6'd4, 4'd0);
      do_trig();
      feed(1, 8'hC0, 8'h01, 0, "rst_mid");
      RST_N = 1'b0;
      #1;
      checks++;
      if (BUSY !== 1'b0 || SAMP_VALID !== 1'b0 || SAMP_DATA !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid: got busy=%b sv=%b sd=%h want 0 0 00", BUSY, SAMP_VALID, SAMP_DATA);
      end
      @(negedge CLK); RST_N = 1'b1;
      do_arm(6'd1, 4'd0);
      do_trig();
      feed(1, 8'h77, 8'h01, 0, "post_rst");
      exp_d[0] = 8'h77;
      readout(1, 5'd0, 4'b1111, "post_rst");
   endtask

`ifdef ARM_TIMEOUT_EN
   task automatic test_timeout;
      int n = 0;
      do_arm(6'd1, 4'd0);
      while (BUSY && n < 100) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (BUSY !== 1'b0 || ERR !== 1'b1 || n < (1 << TB_TO_W) - 1 || n > (1 << TB_TO_W) + 1) begin
         errors++;
         $display("FAIL timeout: got busy=%b err=%b cycles=%0d want 0 1 ~%0d", BUSY, ERR, n, 1 << TB_TO_W);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_full_wrap();
      test_decim();
      test_stall();
      test_err();
      test_abort();
      test_reset_mid();
`ifdef ARM_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
